// File: rtl/sram_axi_bridge_if.sv
// Bundles the bridge's upstream SRAM-like cache port and its AXI3 master
// channels. The master modport is the bridge's side. The slave modport is the
// environment's side: the cache upstream plus the AXI slave downstream.
interface sram_axi_bridge_if;
  // upstream SRAM-like port
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  // AR channel
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [3:0]  arlen;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [31:0] rdata_i;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awlen;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [31:0] wdata_o;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [3:0]  wid;
  logic        wvalid;
  logic        wready;
  // B channel
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok,
    output araddr, arsize, arlen, arburst, arid, arvalid,
    input  arready,
    input  rdata_i, rresp, rlast, rid, rvalid,
    output rready,
    output awaddr, awsize, awlen, awburst, awid, awvalid,
    input  awready,
    output wdata_o, wstrb, wlast, wid, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );

  modport slave (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok,
    input  araddr, arsize, arlen, arburst, arid, arvalid,
    output arready,
    output rdata_i, rresp, rlast, rid, rvalid,
    input  rready,
    input  awaddr, awsize, awlen, awburst, awid, awvalid,
    output awready,
    input  wdata_o, wstrb, wlast, wid, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Single-outstanding bridge from the data cache's SRAM-like miss/write-back
// port to a single-beat AXI3 master. One request is latched in IDLE and
// carried through AR/R or AW+W/B before the next request is accepted.
//
// state | meaning
// IDLE  | waiting for req; addr_ok mirrors req
// AR    | read address presented, waiting for arready
// R     | rready high, waiting for the single read beat
// AW_W  | address and data presented, each retired on its own handshake
// B     | bready high, waiting for the write response
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input logic            clk,
  input logic            rst,
  sram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

  state_t      r_state;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic        r_aw_done, r_w_done;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  logic        w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
  logic [3:0]  w_wstrb;
  logic        w_unused;

  // A handshake in the current cycle counts as done, so AW and W landing
  // together (or the later of the two) moves straight on to B.
  assign w_aw_hs  = r_awvalid & bus.awready;
  assign w_w_hs   = r_wvalid & bus.wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // Response codes and IDs are deliberately ignored.
  assign w_unused = ^{bus.rresp, bus.rlast, bus.rid, bus.bresp, bus.bid};

  // Main sequencer: latches the request and owns every valid/ready output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_size  <= bus.size;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            if (bus.wr) begin
              r_state   <= S_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (bus.rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_AW_W: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_B;
          end
        end
        S_B: begin
          if (bus.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane strobes from the latched size and low address bits.
  always_comb begin
    case (r_size)
      2'd0:    w_wstrb = 4'b0001 << r_addr[1:0];
      2'd1:    w_wstrb = 4'b0011 << r_addr[1:0];
      default: w_wstrb = 4'b1111;
    endcase
  end

  assign bus.addr_ok = (r_state == S_IDLE) & bus.req;
  assign bus.data_ok = ((r_state == S_R) & bus.rvalid) |
                       ((r_state == S_B) & bus.bvalid);
  assign bus.rdata   = bus.rdata_i;

  assign bus.araddr  = r_addr;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arlen   = 4'd0;
  assign bus.arburst = 2'b01;
  assign bus.arid    = AXI_ID;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awaddr  = r_addr;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awlen   = 4'd0;
  assign bus.awburst = 2'b01;
  assign bus.awid    = AXI_ID;
  assign bus.awvalid = r_awvalid;

  assign bus.wdata_o = r_wdata;
  assign bus.wstrb   = w_wstrb;
  assign bus.wlast   = 1'b1;
  assign bus.wid     = AXI_ID;
  assign bus.wvalid  = r_wvalid;
  assign bus.bready  = r_bready;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge. Each request pushes its expected
// transaction to a scoreboard; the AXI side is checked cycle by cycle against
// that entry and it is popped when data_ok completes the transaction.
module tb_sram_axi_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_axi_bridge_if bus ();

  sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } txn_t;

  txn_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Strobe derived lane by lane from the access size and byte offset.
  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s;
    int         lo;
    s  = 4'b0000;
    lo = int'(a[1:0]);
    case (sz)
      2'd0: s[lo] = 1'b1;
      2'd1: begin
        s[lo] = 1'b1;
        if (lo < 3) s[lo + 1] = 1'b1;
      end
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  task automatic bus_defaults();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata_i = 32'h0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    bus.rid     = 4'd0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.bid     = 4'd0;
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
    bus_defaults();
  endtask

  task automatic sb_pop(input string tag, output txn_t t, output bit ok);
    n_tests++;
    ok = (sb.size() != 0);
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s_sb_underflow observed=0 expected=1 entries", tag);
    end
    if (ok) t = sb.pop_front();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int ar_c,
                         input int r_c, input logic [31:0] d, input logic [1:0] resp);
    txn_t t;
    bit   ok;
    start_cycle();
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = sz; bus.addr = a; bus.wdata = 32'h0;
    t.wr = 1'b0; t.addr = a; t.data = d; t.strb = 4'h0; t.size = {1'b0, sz};
    sb.push_back(t);
    #2;
    chk1("rd_c0_addr_ok", bus.addr_ok, 1'b1);
    chk1("rd_c0_arvalid", bus.arvalid, 1'b0);
    chk1("rd_c0_data_ok", bus.data_ok, 1'b0);
    for (int c = 1; c <= r_c; c++) begin
      start_cycle();
      bus.req = 1'b0; bus.addr = $urandom; bus.size = 2'($urandom_range(0, 3));
      bus.arready = (c == ar_c);
      if (c == r_c) begin
        bus.rvalid = 1'b1; bus.rdata_i = d; bus.rresp = resp; bus.rlast = 1'b1; bus.rid = 4'd1;
      end
      #2;
      chk1("rd_arvalid", bus.arvalid, c <= ar_c);
      chk1("rd_rready", bus.rready, c > ar_c);
      chk1("rd_data_ok", bus.data_ok, c == r_c);
      chk1("rd_addr_ok_busy", bus.addr_ok, 1'b0);
      chk1("rd_awvalid", bus.awvalid, 1'b0);
      if (c <= ar_c && sb.size() != 0) begin
        chk32("rd_araddr", bus.araddr, sb[0].addr);
        chk32("rd_arsize", 32'(bus.arsize), 32'(sb[0].size));
        chk32("rd_arlen", 32'(bus.arlen), 32'd0);
        chk32("rd_arburst", 32'(bus.arburst), 32'd1);
        chk32("rd_arid", 32'(bus.arid), 32'd1);
      end
      if (bus.data_ok) begin
        sb_pop("rd", t, ok);
        if (ok) begin
          chk1("rd_sb_kind", t.wr, 1'b0);
          chk32("rd_rdata", bus.rdata, t.data);
        end
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input int aw_c, input int w_c, input int b_c,
                          input bit hold_rd, input logic [31:0] nxt_a);
    txn_t t;
    bit   ok;
    int   hs;
    hs = (aw_c > w_c) ? aw_c : w_c;
    start_cycle();
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = sz; bus.addr = a; bus.wdata = d;
    t.wr = 1'b1; t.addr = a; t.data = d; t.strb = exp_strb(sz, a); t.size = {1'b0, sz};
    sb.push_back(t);
    #2;
    chk1("wr_c0_addr_ok", bus.addr_ok, 1'b1);
    chk1("wr_c0_awvalid", bus.awvalid, 1'b0);
    for (int c = 1; c <= b_c; c++) begin
      start_cycle();
      bus.req = 1'b0; bus.addr = $urandom; bus.wdata = $urandom;
      bus.awready = (c == aw_c);
      bus.wready  = (c == w_c);
      bus.bvalid  = (c == b_c);
      if (c == b_c) begin
        bus.bresp = 2'b11; bus.bid = 4'd7;
      end
      if (hold_rd && c == b_c) begin
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = nxt_a;
      end
      #2;
      chk1("wr_awvalid", bus.awvalid, c <= aw_c);
      chk1("wr_wvalid", bus.wvalid, c <= w_c);
      chk1("wr_bready", bus.bready, c > hs);
      chk1("wr_data_ok", bus.data_ok, c == b_c);
      chk1("wr_addr_ok_busy", bus.addr_ok, 1'b0);
      chk1("wr_arvalid", bus.arvalid, 1'b0);
      if (bus.awvalid && sb.size() != 0) begin
        chk32("wr_awaddr", bus.awaddr, sb[0].addr);
        chk32("wr_awsize", 32'(bus.awsize), 32'(sb[0].size));
        chk32("wr_awlen", 32'(bus.awlen), 32'd0);
        chk32("wr_awburst", 32'(bus.awburst), 32'd1);
        chk32("wr_awid", 32'(bus.awid), 32'd1);
      end
      if (bus.wvalid && sb.size() != 0) begin
        chk32("wr_wdata", bus.wdata_o, sb[0].data);
        chk32("wr_wstrb", 32'(bus.wstrb), 32'(sb[0].strb));
        chk1("wr_wlast", bus.wlast, 1'b1);
        chk32("wr_wid", 32'(bus.wid), 32'd1);
      end
      if (bus.data_ok) begin
        sb_pop("wr", t, ok);
        if (ok) chk1("wr_sb_kind", t.wr, 1'b1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus_defaults();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_awvalid", bus.awvalid, 1'b0);
    chk1("rst_wvalid", bus.wvalid, 1'b0);
    chk1("rst_bready", bus.bready, 1'b0);
    chk1("rst_data_ok", bus.data_ok, 1'b0);
    chk32("rst_araddr", bus.araddr, 32'h0);
    bus.req = 1'b1;
    #1;
    chk1("rst_addr_ok_follows_1", bus.addr_ok, 1'b1);
    bus.req = 1'b0;
    #1;
    chk1("rst_addr_ok_follows_0", bus.addr_ok, 1'b0);
    rst = 1'b0;

    // word read, arready at 1, data at 4
    do_read(32'h1FC0_0010, 2'd2, 1, 4, 32'hDEADBEEF, 2'b00);
    // word write, awready at 1, wready at 3, bvalid at 5
    do_write(32'h0000_0100, 2'd2, 32'h1234_5678, 1, 3, 5, 1'b0, 32'h0);
    // byte write at minimum latency, lane 3
    do_write(32'h0000_0103, 2'd0, 32'hAA00_0000, 1, 1, 2, 1'b0, 32'h0);
    // half write lanes 2-3, wready before awready
    do_write(32'h0000_0102, 2'd1, 32'hBEEF_0000, 2, 1, 3, 1'b0, 32'h0);
    // byte lane 1 and half lanes 0-1
    do_write(32'h0000_0041, 2'd0, 32'h0000_5500, 3, 3, 4, 1'b0, 32'h0);
    do_write(32'h0000_0080, 2'd1, 32'h0000_CAFE, 1, 2, 4, 1'b0, 32'h0);
    // back-to-back: read held high while the write completes
    do_write(32'h0000_0200, 2'd2, 32'h0BAD_F00D, 1, 1, 2, 1'b1, 32'h0000_0300);
    do_read(32'h0000_0300, 2'd2, 1, 2, 32'h3333_4444, 2'b00);
    // read with delayed arready
    do_read(32'h8000_0006, 2'd1, 3, 5, 32'h5A5A_A5A5, 2'b00);

    // reset while in AW_W with wready low
    start_cycle();
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd2; bus.addr = 32'h40; bus.wdata = 32'h55;
    #2;
    chk1("mid_addr_ok", bus.addr_ok, 1'b1);
    start_cycle();
    bus.req = 1'b0; bus.awready = 1'b1;
    #2;
    chk1("mid_awvalid_c1", bus.awvalid, 1'b1);
    chk1("mid_wvalid_c1", bus.wvalid, 1'b1);
    start_cycle();
    #2;
    chk1("mid_awvalid_c2", bus.awvalid, 1'b0);
    chk1("mid_wvalid_c2", bus.wvalid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("mid_rst_wvalid", bus.wvalid, 1'b0);
    chk1("mid_rst_awvalid", bus.awvalid, 1'b0);
    chk1("mid_rst_bready", bus.bready, 1'b0);
    chk1("mid_rst_data_ok", bus.data_ok, 1'b0);
    start_cycle();
    rst = 1'b0;
    #2;
    chk1("post_rst_idle_addr_ok", bus.addr_ok, 1'b0);
    chk1("post_rst_wvalid", bus.wvalid, 1'b0);
    do_read(32'h0000_0044, 2'd2, 1, 2, 32'h7777_0001, 2'b00);

    // SLVERR on the read beat still completes normally
    do_read(32'h0000_0048, 2'd2, 2, 3, 32'hC0DE_0002, 2'b10);
    do_write(32'h0000_004C, 2'd2, 32'hFACE_0003, 1, 1, 2, 1'b0, 32'h0);

    chk32("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Single-outstanding bridge converting the data cache's SRAM-like miss/write-back port (req/addr_ok/data_ok) into an AXI3 master. It sits directly downstream of the data cache: every refill read and dirty write-back issued by the cache becomes exactly one single-beat AXI transaction. One transaction is in flight at a time; no reordering and no buffering beyond one latched request.

## Interface
Parameters:
- `AXI_ID`, default 4'd1: value driven on arid/awid/wid.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req`  in  1  upstream request, held until addr_ok
- `wr`  in  1  1 = write, 0 = read
- `size`  in  2  0 = byte, 1 = half, 2 = word
- `addr`  in  32  byte address
- `wdata`  in  32  write data, already lane-aligned by upstream
- `rdata`  out  32  read data, valid with data_ok
- `addr_ok`  out  1  request accepted this cycle
- `data_ok`  out  1  transaction complete this cycle
- `araddr` / `arsize`  out  32 / 3  read address; arsize = {1'b0, size}
- `arlen` / `arburst` / `arid`  out  4 / 2 / 4  constants 0 / 2'b01 / AXI_ID
- `arvalid`  out  1; `arready`  in  1
- `rdata_i` / `rresp` / `rlast` / `rid`  in  32 / 2 / 1 / 4
- `rvalid`  in  1; `rready`  out  1
- `awaddr` / `awsize` / `awlen` / `awburst` / `awid`  out  as for AR
- `awvalid`  out  1; `awready`  in  1
- `wdata_o` / `wstrb` / `wlast` / `wid`  out  32 / 4 / 1 / 4; wlast constant 1
- `wvalid`  out  1; `wready`  in  1
- `bresp` / `bid`  in  2 / 4; `bvalid`  in  1; `bready`  out  1

## Operation
- States: IDLE, AR, R, AW_W, B.
- IDLE: addr_ok = req (combinational). On req: latch wr, size, addr, wdata; go to AW_W if wr, else AR.
- AR: arvalid = 1, araddr = latched addr. On arvalid & arready -> R.
- R: rready = 1. On rvalid: data_ok = 1, rdata = rdata_i (combinational pass-through) -> IDLE.
- AW_W: awvalid held until its handshake, wvalid held until its handshake, tracked by independent flags aw_done/w_done; either order or the same cycle is legal. Once both are done (including handshakes in the current cycle) -> B; flags cleared.
- B: bready = 1. On bvalid: data_ok = 1 -> IDLE.
- wstrb: size 0 -> 4'b0001 << addr[1:0]; size 1 -> 4'b0011 << addr[1:0]; size 2/3 -> 4'b1111.
- awaddr/araddr are driven exactly as latched, with no alignment. wdata_o = latched wdata.
- rresp/bresp errors and rid/bid values are ignored; the transaction completes normally.
- Inputs on the upstream side are ignored outside IDLE.

## Timing
- Reset (async): state = IDLE; arvalid, rready, awvalid, wvalid, bready, data_ok = 0; aw_done = w_done = 0; latched regs = 0; addr_ok follows req.
- Reset mid-transaction: all valid/ready outputs drop immediately; the outstanding AXI transaction is abandoned.
- Read minimum latency: req/addr_ok at cycle 0; arvalid at cycle 1; with arready at cycle 1 and rvalid at cycle 2, data_ok is asserted at cycle 2.
- Write minimum latency: addr_ok at cycle 0; awvalid and wvalid at cycle 1; with both ready at cycle 1 and bvalid at cycle 2, data_ok is asserted at cycle 2.
- data_ok is a one-cycle pulse. addr_ok cannot coincide with data_ok; the next request is accepted at the earliest the cycle after data_ok.
- Valid signals never drop before their handshake. Address, data and strobe outputs are stable while valid is high.

## Test plan
- Word read 0x1FC0_0010: arready at cycle 1, rvalid with 0xDEADBEEF at cycle 4 -> addr_ok at cycle 0, arvalid cycles 1 only, data_ok and rdata = 0xDEADBEEF at cycle 4, rready high in cycles 2-4.
- Word write 0x0000_0100, data 0x12345678, with awready at cycle 1 and wready at cycle 3 -> awvalid drops after cycle 1, wvalid high cycles 1-3, wstrb = 4'hF, bready from cycle 4, data_ok on bvalid.
- Byte write to 0x0000_0103 -> wstrb = 4'b1000, awsize = 3'b000. Half-word write to 0x...02 -> wstrb = 4'b1100.
- Back-to-back operation: a write-back completes (data_ok) with a read request already held high -> addr_ok on the next cycle, never in the data_ok cycle, and arvalid follows one cycle later.
- Assert rst while in AW_W with wready low -> wvalid and awvalid are 0 in the same cycle; after release, state = IDLE and a fresh read completes normally.
- rresp = 2'b10 on the read data beat -> data_ok is still asserted and rdata is passed through; the FSM returns to IDLE.
